stream_demux_1ton: RTL
======================

Name: stream_demux_1toN

Overview:
Packet-aware 1:N stream demultiplexer. It is the distribution counterpart of the team's N:1 gate-level mux.
- Accepts one valid/ready input stream and steers each packet, whole, to one of N output channels.
- The destination is sampled from the select input on a packet's first beat and locked until that packet's last beat.
- One registered output stage. Sits between a shared producer and N per-channel consumers.

Parameters:
N, 4, number of output channels (N >= 2)
P, $clog2(N), select width (derived; do not override)
W, 8, data width per beat

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid && s_ready
s_data  input  W  input beat data
s_last  input  1  final beat of packet
s_sel  input  P  destination channel; sampled only on a packet's first beat
m_valid  output  N  one-hot output valid; at most one bit set
m_ready  input  N  per-channel ready
m_data  output  W  shared output data bus, qualified by m_valid
m_last  output  1  shared last flag, qualified by m_valid
busy  output  1  high while a packet is in progress (between first and last accepted beat)
cur_sel  output  P  locked destination of the packet in progress

Behaviour:
- Reset: asynchronous assert, synchronous release.
  - m_valid=0, m_data=0, m_last=0, busy=0, cur_sel=0, FSM=IDLE, output stage empty.
  - s_ready is 1 one cycle after rst_n rises.
- FSM states:
  - IDLE: waiting for a packet's first beat.
  - ROUTE: mid-packet, destination locked.
- Transitions:
  - IDLE -> ROUTE: first beat accepted with s_last=0; cur_sel <= s_sel.
  - IDLE stays IDLE: first beat accepted with s_last=1 (single-beat packet). The beat is still routed to s_sel.
  - ROUTE -> IDLE: beat accepted with s_last=1.
  - In ROUTE, s_sel is ignored.
- Destination of an accepted beat: s_sel in IDLE, cur_sel in ROUTE.
- Output stage: one register holding {data, last, dest, vld}.
  - m_valid[i] = vld && (dest==i).
  - The output beat is consumed when m_valid[dest] && m_ready[dest].
- Flow control: s_ready = !vld || m_ready[dest].
  - Full throughput: one beat per cycle while the destination is ready.
  - Latency: 1 cycle from acceptance to m_valid.
- Simultaneous drain and fill: the register is overwritten in the same cycle. A new dest may differ from the old one, so back-to-back packets to different channels run with no bubble.
- Stall: m_data, m_last and m_valid hold stable while m_valid[dest]=1 and m_ready[dest]=0.
- Ready on a non-selected channel has no effect.
- busy = (FSM==ROUTE) || (FSM==IDLE && a first beat with s_last=0 is accepted this cycle) is NOT used. busy is the registered state only: busy = (FSM==ROUTE).
- Out-of-range select (s_sel >= N, possible only when N is not a power of 2), with the macro undefined: the packet is routed to channel N-1.
- Reset mid-packet: the in-flight beat and packet state are discarded. The next accepted beat is treated as a first beat.

Optional Feature:
DEMUX_SELERR_EN.
- Defined:
  - A first beat with s_sel >= N starts a DROP state.
  - s_ready is forced to 1 and all beats of that packet are discarded (never written to the output stage).
  - Output sel_err (1 bit, reset 0) pulses high for exactly one cycle when the first beat is accepted.
  - DROP -> IDLE when the last beat is accepted.
  - Packets to valid channels are unaffected.
- Undefined: there is no sel_err port and no DROP state. Out-of-range maps to N-1 as above.

Test Plan:
1. Reset, then a 3-beat packet with s_sel=2, data 0xA1,0xA2,0xA3, m_ready=4'b1111 -> m_valid=4'b0100 for 3 consecutive cycles starting 1 cycle after the first acceptance; m_last=1 only with 0xA3; busy high from cycle after beat 1 until after beat 3.
2. Lock check: a 4-beat packet with s_sel=1 on beat 1, s_sel toggled to 3 on beats 2-4 -> all 4 beats appear on m_valid[1]; cur_sel=1 throughout.
3. Back-to-back single-beat packets to channels 0,3,1,2 (0x10,0x13,0x11,0x12), all ready -> m_valid = 0001,1000,0010,0100 on consecutive cycles with no bubbles.
4. Backpressure: a packet to channel 3, m_ready[3]=0 for 5 cycles while m_ready[0..2]=1 -> s_ready=0 after the first beat fills the stage; m_data holds its value; no beat is lost or duplicated after m_ready[3] rises.
5. rst_n pulsed low during beat 2 of a 4-beat packet -> m_valid=0 and busy=0 immediately. The next packet with s_sel=0 routes to channel 0 even with no s_last seen.
6. N=3, DEMUX_SELERR_EN defined, 2-beat packet with s_sel=3 -> no m_valid asserted; sel_err high for exactly one cycle; the following packet with s_sel=1 is delivered normally. With the macro undefined, the same packet appears on m_valid[2].

Source files
------------

// File: rtl/stream_demux_1ton.sv
// Packet-aware 1:N valid/ready demultiplexer with one registered output stage.
// Optional DEMUX_SELERR_EN: out-of-range selects drop the whole packet and pulse sel_err.
module stream_demux_1ton #(
    parameter int N = 4,
    parameter int P = $clog2(N),
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    input  logic [P-1:0] s_sel,
    output logic [N-1:0] m_valid,
    input  logic [N-1:0] m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         busy,
`ifdef DEMUX_SELERR_EN
    output logic         sel_err,
`endif
    output logic [P-1:0] cur_sel
);

`ifdef DEMUX_SELERR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ROUTE = 2'd1, DROP = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, ROUTE = 1'b1} state_t;
`endif

    localparam logic [P-1:0] SEL_MAX = P'(N - 1);

    state_t         state_reg;
    logic           init_reg;
    logic           vld_reg;
    logic           last_reg;
    logic [W-1:0]   data_reg;
    logic [P-1:0]   dest_reg;
    logic [P-1:0]   cur_sel_reg;
`ifdef DEMUX_SELERR_EN
    logic           sel_err_reg;
`endif

    logic           sel_bad;
    logic [P-1:0]   first_sel;
    logic [P-1:0]   in_dest;
    logic           out_free;
    logic           drop_beat;
    logic           accept;
    logic           load;
    logic           consume;

    // A power-of-two channel count can never see an out-of-range select.
    generate
        if ((1 << P) == N) begin : g_sel_full
            assign sel_bad = 1'b0;
        end else begin : g_sel_partial
            assign sel_bad = ({1'b0, s_sel} >= (P + 1)'(N));
        end
    endgenerate

    always_comb begin
        out_free  = !vld_reg || m_ready[dest_reg];
        first_sel = sel_bad ? SEL_MAX : s_sel;
        in_dest   = (state_reg == ROUTE) ? cur_sel_reg : first_sel;
        drop_beat = 1'b0;
`ifdef DEMUX_SELERR_EN
        drop_beat = (state_reg == DROP) || ((state_reg == IDLE) && sel_bad);
        s_ready   = init_reg && ((state_reg == DROP) || out_free);
`else
        s_ready   = init_reg && out_free;
`endif
        accept    = s_valid && s_ready;
        load      = accept && !drop_beat;
        consume   = vld_reg && m_ready[dest_reg];
    end

    // init_reg holds s_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            init_reg    <= 1'b0;
            vld_reg     <= 1'b0;
            last_reg    <= 1'b0;
            data_reg    <= '0;
            dest_reg    <= '0;
            cur_sel_reg <= '0;
`ifdef DEMUX_SELERR_EN
            sel_err_reg <= 1'b0;
`endif
        end else begin
            init_reg <= 1'b1;
            if (load) begin
                vld_reg  <= 1'b1;
                data_reg <= s_data;
                last_reg <= s_last;
                dest_reg <= in_dest;
            end else if (consume) begin
                vld_reg  <= 1'b0;
            end
`ifdef DEMUX_SELERR_EN
            sel_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
`ifdef DEMUX_SELERR_EN
                    if (accept && sel_bad) begin
                        sel_err_reg <= 1'b1;
                        if (!s_last) state_reg <= DROP;
                    end else
`endif
                    if (accept && !s_last) begin
                        state_reg   <= ROUTE;
                        cur_sel_reg <= first_sel;
                    end
                end
                ROUTE: begin
                    if (accept && s_last) state_reg <= IDLE;
                end
`ifdef DEMUX_SELERR_EN
                DROP: begin
                    if (accept && s_last) state_reg <= IDLE;
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_valid
            assign m_valid[gi] = vld_reg && (dest_reg == P'(gi));
        end
    endgenerate

    assign m_data  = data_reg;
    assign m_last  = last_reg;
    assign busy    = (state_reg == ROUTE);
    assign cur_sel = cur_sel_reg;
`ifdef DEMUX_SELERR_EN
    assign sel_err = sel_err_reg;
`endif

endmodule
